// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS fetch front end: the fetch FSM state
// encoding, datapath widths, and the branch offset helper.
package cpu_pkg;

  localparam int WORD_W  = 32;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_t;

  // A branch immediate counts words; sign-extend it and scale it to a byte offset.
  function automatic logic [WORD_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(WORD_W - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection. Jump has top priority, then a taken
// conditional branch (PCSrc = branch & zero), then sequential fall-through.
// All additions wrap modulo 2^32.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0]  pc,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  input  logic [IMM_W-1:0]   imm,
  input  logic [JADDR_W-1:0] jump_addr,
  output logic [WORD_W-1:0]  next_pc,
  output logic [WORD_W-1:0]  pc_plus4
);

  logic pcsrc;

  assign pc_plus4 = pc + 32'd4;
  assign pcsrc    = branch & zero;

  // Jump keeps the upper nibble of pc+4; a branch is relative to pc+4.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[WORD_W-1:WORD_W-4], jump_addr, 2'b00};
    end else if (pcsrc) begin
      next_pc = pc_plus4 + branch_offset(imm);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Sequential fetch front end of the MIPS core. Holds the PC, issues one
// instruction-memory request at a time, holds the returned instruction for
// execute, and on its acknowledge consumes the branch/jump outcome to pick
// the next PC. Optional statistics counters are built when the macro
// FETCH_STATS_EN is defined.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000
`ifdef FETCH_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [WORD_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [WORD_W-1:0]  imem_rsp_data,
  output logic [WORD_W-1:0]  instr_out,
  output logic               instr_valid,
  input  logic               instr_ack,
  input  logic               branch_in,
  input  logic               zero_in,
  input  logic               jump_in,
  input  logic [IMM_W-1:0]   imm_in,
  input  logic [JADDR_W-1:0] jump_addr_in,
  output logic [WORD_W-1:0]  pc_out,
  output logic [WORD_W-1:0]  pc_plus4_out
`ifdef FETCH_STATS_EN
  , output logic [CNT_W-1:0] fetch_cnt
  , output logic [CNT_W-1:0] taken_cnt
  , output logic [CNT_W-1:0] jump_cnt
`endif
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              req_valid_q, req_valid_d;
  logic [WORD_W-1:0] next_pc;
  logic [WORD_W-1:0] pc_plus4;
  logic              req_fire;
  logic              ack_fire;

  next_pc_calc u_next_pc_calc (
    .pc        (pc_q),
    .jump      (jump_in),
    .branch    (branch_in),
    .zero      (zero_in),
    .imm       (imm_in),
    .jump_addr (jump_addr_in),
    .next_pc   (next_pc),
    .pc_plus4  (pc_plus4)
  );

  // A request only counts once it has actually been presented, so the
  // first cycle out of reset can never be mistaken for an accepted fetch.
  assign req_fire = (state_q == S_REQ) && req_valid_q && imem_req_ready;
  assign ack_fire = (state_q == S_ISSUE) && instr_ack;

  // Fetch FSM: request, wait for the response, hold until execute acks.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    req_valid_d   = req_valid_q;
    case (state_q)
      S_REQ: begin
        req_valid_d = 1'b1;
        if (req_fire) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d       = imem_rsp_data;
          instr_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ack_fire) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          req_valid_d   = 1'b1;
          state_d       = S_REQ;
        end
      end
      default: begin
        state_d       = S_REQ;
        instr_valid_d = 1'b0;
        req_valid_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset parks the unit at the reset vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      req_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      req_valid_q   <= req_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign instr_out      = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc_out         = pc_q;
  assign pc_plus4_out   = pc_plus4;

`ifdef FETCH_STATS_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;
  logic             taken_fire;
  logic             jump_fire;

  // A branch only counts as taken when it actually steered the PC, so a
  // jump that overrides a taken branch is counted as a jump alone.
  assign taken_fire = ack_fire && branch_in && zero_in && !jump_in;
  assign jump_fire  = ack_fire && jump_in;

  // Saturating event counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    taken_cnt_d = taken_cnt_q;
    jump_cnt_d  = jump_cnt_q;
    if (req_fire && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
    if (taken_fire && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
    if (jump_fire && (jump_cnt_q != '1)) begin
      jump_cnt_d = jump_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared with the rest of the unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      taken_cnt_q <= '0;
      jump_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      jump_cnt_q  <= jump_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign taken_cnt = taken_cnt_q;
  assign jump_cnt  = jump_cnt_q;
`endif

endmodule
